// File: rtl/pulse_resp_loader.sv
// Coefficient loader for the parallel DFE: fetches the pulse-response words from
// on-chip memory into a local buffer, streams them to the DFE, then waits for done_wait.
module pulse_resp_loader #(
  parameter int PULSE_RESPONSE_LENGTH = 5,
  parameter int ADDR_WIDTH            = 8,
  parameter int BASE_ADDR             = 0,
  parameter int MEM_LATENCY           = 1,
  parameter int TIMEOUT_CYCLES        = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [63:0]           mem_rdata,
  output logic                  load_mem,
  output logic [7:0]            location,
  output logic [63:0]           mem_data,
  input  logic                  done_wait,
  output logic                  busy,
  output logic                  loaded,
  output logic                  error
);

  localparam int N  = PULSE_RESPONSE_LENGTH;
  localparam int CW = $clog2(N + 3);
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST     = CW'(N - 1);
  localparam logic [CW-1:0] FINAL_J  = CW'(N + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, FETCH, STREAM, WAIT_DONE, LOADED, ERROR} state_t;

  typedef struct packed {
    logic          valid;
    logic [CW-1:0] idx;
  } tag_t;

  state_t                state_q, state_d;
  logic                  mem_rd_q, mem_rd_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  load_mem_q, load_mem_d;
  logic [7:0]            location_q, location_d;
  logic [63:0]           mem_data_q, mem_data_d;
  logic                  busy_q, busy_d;
  logic                  loaded_q, loaded_d;
  logic                  error_q, error_d;
  logic [CW-1:0]         rd_idx_q, rd_idx_d;
  logic [CW-1:0]         j_q, j_d;
  logic [TW-1:0]         wait_cnt_q, wait_cnt_d;
  logic [63:0]           buffer_q [N];
  logic [63:0]           buffer_d [N];
  tag_t                  pipe_q [MEM_LATENCY];
  tag_t                  pipe_d [MEM_LATENCY];

  logic [CW-1:0] j_inc;
  logic [CW-1:0] loc_idx;
  logic [CW-1:0] data_idx;
  tag_t          ret_tag;

  assign j_inc    = j_q + CW'(1);
  assign loc_idx  = (j_inc >= LAST) ? LAST : j_inc;
  assign data_idx = (j_q >= LAST) ? LAST : j_q;
  assign ret_tag  = pipe_q[MEM_LATENCY-1];

  // NOTE: every variable gets a default at the top of the block so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    rd_idx_d   = rd_idx_q;
    load_mem_d = 1'b0;
    location_d = location_q;
    mem_data_d = mem_data_q;
    j_d        = j_q;
    wait_cnt_d = wait_cnt_q;
    buffer_d   = buffer_q;

    // Each issued read is tagged with its index; the tag leaves the pipe with its data.
    pipe_d[0] = '{valid: mem_rd_q, idx: rd_idx_q};
    for (int i = 1; i < MEM_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    if (ret_tag.valid) buffer_d[BW'(ret_tag.idx)] = mem_rdata;

    unique case (state_q)
      IDLE, LOADED, ERROR: begin
        if (start) begin
          state_d    = FETCH;
          mem_rd_d   = 1'b1;
          mem_addr_d = ADDR_WIDTH'(BASE_ADDR);
          rd_idx_d   = '0;
        end
      end
      FETCH: begin
        if (mem_rd_q && rd_idx_q != LAST) begin
          mem_rd_d   = 1'b1;
          mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
          rd_idx_d   = rd_idx_q + CW'(1);
        end
        if (ret_tag.valid && ret_tag.idx == LAST) begin
          state_d    = STREAM;
          load_mem_d = 1'b1;
          location_d = '0;
          mem_data_d = buffer_q[0];
          j_d        = '0;
        end
      end
      STREAM: begin
        if (j_q == FINAL_J) begin
          state_d    = WAIT_DONE;
          wait_cnt_d = '0;
        end else begin
          // Data trails location by one beat; the DFE writes to the index it latched last.
          load_mem_d = 1'b1;
          j_d        = j_inc;
          location_d = 8'(loc_idx);
          mem_data_d = buffer_q[BW'(data_idx)];
        end
      end
      WAIT_DONE: begin
        if (done_wait)                    state_d = LOADED;
        else if (wait_cnt_q == TMO_LAST)  state_d = ERROR;
        else                              wait_cnt_d = wait_cnt_q + TW'(1);
      end
      default: state_d = IDLE;
    endcase

    busy_d   = (state_d == FETCH) || (state_d == STREAM) || (state_d == WAIT_DONE);
    loaded_d = (state_d == LOADED);
    error_d  = (state_d == ERROR);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      load_mem_q <= 1'b0;
      location_q <= '0;
      mem_data_q <= '0;
      busy_q     <= 1'b0;
      loaded_q   <= 1'b0;
      error_q    <= 1'b0;
      rd_idx_q   <= '0;
      j_q        <= '0;
      wait_cnt_q <= '0;
      // NOTE: the buffer is a handful of flops, not a RAM macro, so clearing it on reset is cheap and deterministic.
      for (int i = 0; i < N; i++) buffer_q[i] <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      load_mem_q <= load_mem_d;
      location_q <= location_d;
      mem_data_q <= mem_data_d;
      busy_q     <= busy_d;
      loaded_q   <= loaded_d;
      error_q    <= error_d;
      rd_idx_q   <= rd_idx_d;
      j_q        <= j_d;
      wait_cnt_q <= wait_cnt_d;
      buffer_q   <= buffer_d;
      pipe_q     <= pipe_d;
    end
  end

  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign load_mem = load_mem_q;
  assign location = location_q;
  assign mem_data = mem_data_q;
  assign busy     = busy_q;
  assign loaded   = loaded_q;
  assign error    = error_q;

endmodule

// File: tb/tb_pulse_resp_loader.sv
// Randomized bench for pulse_resp_loader: two instances (latency 1 / base 0, latency 3 / base 0xFE)
// checked against expected read/stream/handshake timelines derived from the coefficient-load rules.
module tb_pulse_resp_loader;

  localparam int N = 5;
  localparam logic [63:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic start_req = 1'b0;
  logic done_wait = 1'b0;
  int   sel = 0;

  logic        start_a, start_b;
  logic        rd_a, rd_b, ld_a, ld_b, busy_a, busy_b, loaded_a, loaded_b, error_a, error_b;
  logic [7:0]  addr_a, addr_b, loc_a, loc_b;
  logic [63:0] rdata_a, rdata_b, data_a, data_b;

  assign start_a = start_req && (sel == 0);
  assign start_b = start_req && (sel == 1);

  pulse_resp_loader u_a (
    .clk(clk), .rstn(rstn), .start(start_a),
    .mem_rd(rd_a), .mem_addr(addr_a), .mem_rdata(rdata_a),
    .load_mem(ld_a), .location(loc_a), .mem_data(data_a),
    .done_wait(done_wait), .busy(busy_a), .loaded(loaded_a), .error(error_a)
  );

  pulse_resp_loader #(
    .MEM_LATENCY(3), .BASE_ADDR(254), .TIMEOUT_CYCLES(16)
  ) u_b (
    .clk(clk), .rstn(rstn), .start(start_b),
    .mem_rd(rd_b), .mem_addr(addr_b), .mem_rdata(rdata_b),
    .load_mem(ld_b), .location(loc_b), .mem_data(data_b),
    .done_wait(done_wait), .busy(busy_b), .loaded(loaded_b), .error(error_b)
  );

  // Memory model: data for a read appears exactly MEM_LATENCY cycles after the strobe.
  logic [63:0] mem [256];
  logic [2:0]  vp_a = '0, vp_b = '0;
  logic [7:0]  ap_a [3];
  logic [7:0]  ap_b [3];
  always @(posedge clk) begin
    vp_a <= {vp_a[1:0], rd_a};
    vp_b <= {vp_b[1:0], rd_b};
    ap_a[0] <= addr_a; ap_a[1] <= ap_a[0]; ap_a[2] <= ap_a[1];
    ap_b[0] <= addr_b; ap_b[1] <= ap_b[0]; ap_b[2] <= ap_b[1];
  end
  assign rdata_a = vp_a[0] ? mem[ap_a[0]] : JUNK;
  assign rdata_b = vp_b[2] ? mem[ap_b[2]] : JUNK;

  logic        m_rd, m_ld, m_busy, m_loaded, m_error;
  logic [7:0]  m_addr, m_loc;
  logic [63:0] m_data;
  assign m_rd     = sel ? rd_b     : rd_a;
  assign m_ld     = sel ? ld_b     : ld_a;
  assign m_busy   = sel ? busy_b   : busy_a;
  assign m_loaded = sel ? loaded_b : loaded_a;
  assign m_error  = sel ? error_b  : error_a;
  assign m_addr   = sel ? addr_b   : addr_a;
  assign m_loc    = sel ? loc_b    : loc_a;
  assign m_data   = sel ? data_b   : data_a;

  int n_tests = 0;
  int n_fail  = 0;

  int         rd_cyc_q [$];
  logic [7:0] rd_adr_q [$];
  int         ld_cyc_q [$];
  logic [7:0] ld_loc_q [$];
  logic [63:0] ld_dat_q [$];
  int loaded_cyc = -1;
  int error_cyc  = -1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_log();
    rd_cyc_q.delete(); rd_adr_q.delete();
    ld_cyc_q.delete(); ld_loc_q.delete(); ld_dat_q.delete();
    loaded_cyc = -1;
    error_cyc  = -1;
  endtask

  // Advance to the next falling edge and log what the selected instance shows this cycle.
  task automatic step();
    @(negedge clk);
    if (m_rd) begin rd_cyc_q.push_back(cyc); rd_adr_q.push_back(m_addr); end
    if (m_ld) begin
      ld_cyc_q.push_back(cyc); ld_loc_q.push_back(m_loc); ld_dat_q.push_back(m_data);
    end
    if (m_loaded && loaded_cyc < 0) loaded_cyc = cyc;
    if (m_error && error_cyc < 0)   error_cyc  = cyc;
  endtask

  // dmode: 0 = done_wait rises d cycles into WAIT_DONE, 1 = never (timeout), 2 = already high.
  task automatic run_load(input int inst, input int dmode, input int d, input bit noisy);
    int lat, base, tmo, s, w, fin, idx;
    lat  = inst ? 3 : 1;
    base = inst ? 254 : 0;
    tmo  = inst ? 16 : 64;
    step();
    sel = inst;
    done_wait = (dmode == 2);
    clear_log();
    s = cyc;
    start_req = 1'b1;
    w = s + 2 * N + lat + 3;
    fin = (dmode == 1) ? w + tmo : (dmode == 2) ? w + 1 : w + d + 1;
    while (cyc < fin + 8) begin
      step();
      start_req = noisy && (cyc == s + 2 || cyc == s + N + lat + 3);
      if (dmode == 0 && cyc == w + d) done_wait = 1'b1;
      if (cyc == s + 1) begin
        check("busy_after_start", 64'(m_busy), 64'(1));
        check("loaded_cleared", 64'(m_loaded), 64'(0));
        check("error_cleared", 64'(m_error), 64'(0));
      end
    end
    check("n_mem_rd", 64'(rd_cyc_q.size()), 64'(N));
    for (int k = 0; k < N && k < rd_cyc_q.size(); k++) begin
      check("rd_cycle", 64'(rd_cyc_q[k]), 64'(s + 1 + k));
      check("rd_addr", 64'(rd_adr_q[k]), 64'((base + k) % 256));
    end
    check("n_load_mem", 64'(ld_cyc_q.size()), 64'(N + 2));
    for (int j = 0; j < N + 2 && j < ld_cyc_q.size(); j++) begin
      idx = (j == 0) ? 0 : ((j - 1 < N - 1) ? j - 1 : N - 1);
      check("ld_cycle", 64'(ld_cyc_q[j]), 64'(s + N + lat + 1 + j));
      check("ld_location", 64'(ld_loc_q[j]), 64'((j < N - 1) ? j : N - 1));
      check("ld_data", ld_dat_q[j], mem[(base + idx) % 256]);
    end
    if (dmode == 1) begin
      check("error_at", 64'(error_cyc), 64'(w + tmo));
      check("loaded_never", 64'(loaded_cyc), 64'(-1));
      check("error_final", 64'(m_error), 64'(1));
    end else begin
      check("loaded_at", 64'(loaded_cyc), 64'(fin));
      check("error_never", 64'(error_cyc), 64'(-1));
      check("loaded_final", 64'(m_loaded), 64'(1));
    end
    check("busy_final", 64'(m_busy), 64'(0));
  endtask

  task automatic reset_mid_stream();
    int s;
    step();
    sel = 0;
    done_wait = 1'b0;
    clear_log();
    s = cyc;
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    while (cyc < s + N + 1 + 1 + 3) step();
    check("pre_reset_load_mem", 64'(m_ld), 64'(1));
    check("pre_reset_location", 64'(m_loc), 64'(3));
    #2 rstn = 1'b0;
    #1;
    check("rst_load_mem", 64'(m_ld), 64'(0));
    check("rst_location", 64'(m_loc), 64'(0));
    check("rst_mem_data", m_data, 64'(0));
    check("rst_busy", 64'(m_busy), 64'(0));
    check("rst_mem_rd", 64'(m_rd), 64'(0));
    step();
    rstn = 1'b1;
    clear_log();
    repeat (50) step();
    check("quiet_mem_rd", 64'(rd_cyc_q.size()), 64'(0));
    check("quiet_load_mem", 64'(ld_cyc_q.size()), 64'(0));
    check("quiet_busy", 64'(m_busy), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
    mem[0] = 64'h0000_0000_0000_00A0; mem[1] = 64'h0000_0000_0000_00A1;
    mem[2] = 64'h0000_0000_0000_00A2; mem[3] = 64'h0000_0000_0000_00A3;
    mem[4] = 64'h0000_0000_0000_00A4;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sel = i;
      #1;
      check("reset_mem_rd", 64'(m_rd), 64'(0));
      check("reset_mem_addr", 64'(m_addr), 64'(0));
      check("reset_load_mem", 64'(m_ld), 64'(0));
      check("reset_location", 64'(m_loc), 64'(0));
      check("reset_mem_data", m_data, 64'(0));
      check("reset_status", {61'd0, m_busy, m_loaded, m_error}, 64'(0));
    end
    @(negedge clk);
    rstn = 1'b1;

    run_load(0, 0, 3, 1'b0);     // basic load, latency 1
    run_load(1, 0, 2, 1'b0);     // latency 3 with address wrap
    run_load(1, 1, 0, 1'b0);     // timeout
    run_load(1, 0, 15, 1'b0);    // restart from ERROR, done on the last allowed cycle
    run_load(0, 0, 63, 1'b1);    // start pulses ignored, done at timeout boundary
    run_load(0, 2, 0, 1'b0);     // reload from LOADED with done_wait already high
    for (int t = 0; t < 8; t++) begin
      int inst, dmode;
      inst  = int'($urandom_range(0, 1));
      dmode = int'($urandom_range(0, 2));
      run_load(inst, dmode, int'($urandom_range(0, inst ? 15 : 63)), 1'($urandom_range(0, 1)));
    end
    reset_mid_stream();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_resp_loader.md
Name: pulse_resp_loader

Overview:
- Upstream control stage for the parallel DFE. Reads PULSE_RESPONSE_LENGTH 64-bit pulse-response coefficient words from on-chip memory into a local buffer.
- Streams the words to the DFE over its load_mem/location/mem_data interface, then waits for the DFE's done_wait.
- Gives the top level a single start/busy/loaded/error handshake, so coefficient reload needs no external sequencing.

Parameters:
- PULSE_RESPONSE_LENGTH, 5: number of coefficient words; range 2..255.
- ADDR_WIDTH, 8: on-chip memory address width.
- BASE_ADDR, 0: memory address of coefficient 0; coefficient k is at BASE_ADDR+k.
- MEM_LATENCY, 1: read latency in cycles from mem_rd to mem_rdata valid; range 1..3.
- TIMEOUT_CYCLES, 64: maximum cycles spent in WAIT_DONE before the block flags an error.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to (re)load coefficients
- mem_rd  out  1  memory read strobe
- mem_addr  out  ADDR_WIDTH  memory read address
- mem_rdata  in  64  memory read data, valid MEM_LATENCY cycles after mem_rd
- load_mem  out  1  to DFE: coefficient write strobe
- location  out  8  to DFE: coefficient index
- mem_data  out  64  to DFE: coefficient word
- done_wait  in  1  from DFE: coefficients accepted (sticky high)
- busy  out  1  high in every state except IDLE, LOADED and ERROR
- loaded  out  1  high in LOADED
- error  out  1  high in ERROR

Behaviour:
- Reset (async, rstn low):
  - state=IDLE.
  - All outputs 0: mem_rd, mem_addr, load_mem, location, mem_data, busy, loaded, error.
  - Buffer, counters and the latency pipeline are cleared.
  - Reset asserted mid-operation aborts immediately. No partial stream continues after release.
- States: IDLE, FETCH, STREAM, WAIT_DONE, LOADED, ERROR. All outputs are registered.
- IDLE/LOADED/ERROR:
  - start=1 moves to FETCH and clears loaded/error on the same edge.
  - start in any other state is ignored; there is no queuing.
- FETCH:
  - mem_rd=1 for exactly PULSE_RESPONSE_LENGTH consecutive cycles, with mem_addr=BASE_ADDR+0, +1, … in order.
  - A MEM_LATENCY-deep shift register of {valid, index} tags the returns. Each mem_rdata is captured into buffer[index] on the cycle its tag exits the pipeline.
  - When the last word (index PULSE_RESPONSE_LENGTH-1) is captured, move to STREAM.
  - Total FETCH duration = PULSE_RESPONSE_LENGTH + MEM_LATENCY cycles.
- STREAM:
  - load_mem=1 for exactly PULSE_RESPONSE_LENGTH+2 consecutive cycles, j=0..PULSE_RESPONSE_LENGTH+1.
  - location = min(j, PULSE_RESPONSE_LENGTH-1).
  - mem_data = buffer[min(max(j-1,0), PULSE_RESPONSE_LENGTH-1)].
  - The data therefore lags location by one cycle: the DFE latches location and writes mem_data to the previously latched index.
  - The two trailing cycles repeat the last index and word, so the DFE load counter reaches PULSE_RESPONSE_LENGTH+2.
  - After cycle j=PULSE_RESPONSE_LENGTH+1: load_mem=0, location/mem_data hold their last values, move to WAIT_DONE.
- WAIT_DONE:
  - The timeout counter starts at 0 and increments each cycle.
  - done_wait=1 sampled → LOADED.
  - Counter reaching TIMEOUT_CYCLES-1 with done_wait=0 → ERROR.
  - If done_wait is already high on entry, LOADED follows on the next edge.
- LOADED: loaded=1, everything else idle. ERROR: error=1.
- Widths: location is 8 bits. Buffer index and counters are sized ceil(log2(PULSE_RESPONSE_LENGTH+3)). mem_addr wraps modulo 2^ADDR_WIDTH with no error.
- mem_rd is never asserted outside FETCH. load_mem is never asserted outside STREAM.

Test Plan:
- Basic load (defaults, memory words 0x…A0..0x…A4, start pulse at cycle 0):
  - mem_rd at cycles 1–5 with addresses 0–4.
  - load_mem high cycles 7–13 (7 cycles).
  - location sequence 0,1,2,3,4,4,4; mem_data sequence A0,A0,A1,A2,A3,A4,A4.
  - The DFE model then raises done_wait → loaded=1, busy=0.
- MEM_LATENCY=3, BASE_ADDR=0xFE:
  - Addresses 0xFE,0xFF,0x00,0x01,0x02 (wrap).
  - FETCH lasts 8 cycles and the buffer contents are correct.
- Timeout, TIMEOUT_CYCLES=16, done_wait tied 0:
  - error=1 exactly 16 cycles after load_mem falls; loaded=0.
  - A new start then clears error and reloads.
- start pulses during FETCH and STREAM are ignored:
  - Exactly 5 mem_rd and 7 load_mem cycles occur; no second sequence follows.
- rstn asserted during STREAM at j=3:
  - load_mem, location and mem_data go to 0 asynchronously; state=IDLE.
  - After release, with no start, no mem_rd or load_mem activity occurs for 50 cycles.
- Reload from LOADED with done_wait already high:
  - The full FETCH/STREAM sequence repeats.
  - LOADED is re-entered one cycle after STREAM ends.
